// File: rtl/line_mem_responder.sv
// Line memory responder: accepts one line read/write at a time and completes it
// with a single mem_ready pulse a fixed LATENCY after accept.
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write; accepts on the next edge
//   BUSY  | latency countdown on latched command, address and data
//   RESP  | mem_ready pulse cycle; always returns to IDLE
module line_mem_responder #(
    parameter int LATENCY    = 5,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err,
    output logic [15:0]  rd_cnt,
    output logic [15:0]  wr_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int            DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]    CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state, state_next;
    logic [3:0]              cnt, cnt_next;
    logic                    cmd_wr;
    logic [27:0]             addr_q;
    logic [127:0]            wdata_q;
    logic                    accept, enter_resp, err_set;
    logic                    op_wr;
    logic [DEPTH_LOG2-1:0]   op_idx;
    logic [127:0]            op_wdata;
    logic [127:0]            lines [DEPTH];

    // With LATENCY=1 the accept edge is also the RESP edge, so the operation
    // must come straight from the inputs rather than the latches.
    always_comb begin
        op_wr    = cmd_wr;
        op_idx   = addr_q[DEPTH_LOG2-1:0];
        op_wdata = wdata_q;
        if (state == IDLE) begin
            op_wr    = mem_write;
            op_idx   = mem_addr[DEPTH_LOG2-1:0];
            op_wdata = mem_wdata;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept   = 1'b1;
                    err_set  = mem_read && mem_write;
                    cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!mem_read && !mem_write) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                    err_set    = 1'b1;
                end else begin
                    err_set  = (mem_write != cmd_wr) || (mem_addr != addr_q);
                    cnt_next = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                        cnt_next   = 4'd0;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cmd_wr    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
            rd_cnt    <= 16'd0;
            wr_cnt    <= 16'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mem_ready <= enter_resp;
            if (accept) begin
                cmd_wr  <= mem_write;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (enter_resp) begin
                if (op_wr) begin
                    if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
                end else begin
                    if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
                    mem_rdata <= lines[op_idx];
                end
            end
        end
    end

    // Storage is deliberately not reset; rst only blocks an in-flight commit.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && op_wr) begin
            lines[op_idx] <= op_wdata;
        end
    end

endmodule
